// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback collector between the execute stage and the scoreboard.
// Each non-back-pressurable result source feeds its own small FIFO; the FIFOs are
// drained onto NR_WB_PORTS scoreboard write ports by a round-robin arbiter.
// Optional feature macro: WB_ARB_BYPASS_EN (empty-FIFO results may go straight to a port).
module wb_arbiter #(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_SRC-1:0]                    src_valid_i,
  input  logic [NR_SRC*TRANS_ID_BITS-1:0]      src_trans_id_i,
  input  logic [NR_SRC*XLEN-1:0]               src_result_i,
  input  logic [NR_SRC-1:0]                    src_ex_valid_i,
  input  logic [NR_SRC*XLEN-1:0]               src_ex_cause_i,
  output logic [NR_SRC-1:0]                    src_afull_o,
  output logic [NR_WB_PORTS-1:0]               wb_valid_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS*XLEN-1:0]          wb_result_o,
  output logic [NR_WB_PORTS-1:0]               wb_ex_valid_o,
  output logic [NR_WB_PORTS*XLEN-1:0]          wb_ex_cause_o,
  output logic                                 overflow_o
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SRC_W   = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  // Entry layout: {trans_id, result, ex_valid, ex_cause}
  localparam int unsigned ENTRY_W = TRANS_ID_BITS + XLEN + 1 + XLEN;

  logic [ENTRY_W-1:0] mem_r    [NR_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r [NR_SRC];
  logic [PTR_W-1:0]   wr_ptr_r [NR_SRC];
  logic [CNT_W-1:0]   cnt_r    [NR_SRC];
  logic [SRC_W-1:0]   rr_r;
  logic               overflow_r;

  logic [ENTRY_W-1:0] in_entry_s [NR_SRC];
  logic [ENTRY_W-1:0] head_s     [NR_SRC];
  logic [NR_SRC-1:0]  cand_s;      // source competes for a port this cycle
  logic [NR_SRC-1:0]  byp_cand_s;  // candidate only through the bypass path
  logic [NR_SRC-1:0]  grant_s;
  logic [NR_SRC-1:0]  byp_s;       // granted via bypass: input goes straight out
  logic [NR_SRC-1:0]  push_s;
  logic [NR_SRC-1:0]  pop_s;
  logic [NR_SRC-1:0]  drop_s;
  logic [SRC_W-1:0]   rr_nxt_s;

  // Pack inputs, pick FIFO heads, and work out which sources are competing.
  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      in_entry_s[s] = {src_trans_id_i[s*TRANS_ID_BITS +: TRANS_ID_BITS],
                       src_result_i[s*XLEN +: XLEN],
                       src_ex_valid_i[s],
                       src_ex_cause_i[s*XLEN +: XLEN]};
      head_s[s] = mem_r[s][rd_ptr_r[s]];
`ifdef WB_ARB_BYPASS_EN
      byp_cand_s[s] = src_valid_i[s] && (cnt_r[s] == '0) && !flush_i;
`else
      byp_cand_s[s] = 1'b0;
`endif
      cand_s[s] = (cnt_r[s] != '0) || byp_cand_s[s];
    end
  end

  // Round-robin scan from rr_r; the k-th candidate found drives port k.
  always_comb begin
    int n;
    int idx;
    n             = 0;
    idx           = 0;
    grant_s       = '0;
    byp_s         = '0;
    rr_nxt_s      = rr_r;
    wb_valid_o    = '0;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_valid_o = '0;
    wb_ex_cause_o = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      idx = (int'(rr_r) + i) % NR_SRC;
      if (cand_s[idx] && (n < NR_WB_PORTS)) begin
        grant_s[idx] = 1'b1;
        byp_s[idx]   = byp_cand_s[idx];
        wb_valid_o[n] = 1'b1;
        if (byp_cand_s[idx]) begin
          {wb_trans_id_o[n*TRANS_ID_BITS +: TRANS_ID_BITS], wb_result_o[n*XLEN +: XLEN],
           wb_ex_valid_o[n], wb_ex_cause_o[n*XLEN +: XLEN]} = in_entry_s[idx];
        end else begin
          {wb_trans_id_o[n*TRANS_ID_BITS +: TRANS_ID_BITS], wb_result_o[n*XLEN +: XLEN],
           wb_ex_valid_o[n], wb_ex_cause_o[n*XLEN +: XLEN]} = head_s[idx];
        end
        rr_nxt_s = SRC_W'((idx + 1) % NR_SRC);
        n        = n + 1;
      end else begin
        grant_s[idx] = 1'b0;
      end
    end
  end

  // Per-FIFO push/pop/drop decisions; a pop frees the slot a same-cycle push needs.
  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      pop_s[s] = grant_s[s] && !byp_s[s];
      if (src_valid_i[s] && !byp_s[s]) begin
        push_s[s] = (cnt_r[s] != CNT_W'(FIFO_DEPTH)) || pop_s[s];
        drop_s[s] = !push_s[s];
      end else begin
        push_s[s] = 1'b0;
        drop_s[s] = 1'b0;
      end
      src_afull_o[s] = (cnt_r[s] >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

  assign overflow_o = overflow_r;

  // FIFO storage, pointers, counts, rr pointer and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_r       <= '0;
      overflow_r <= 1'b0;
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_r[s] <= '0;
        wr_ptr_r[s] <= '0;
        cnt_r[s]    <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) begin
          mem_r[s][d] <= '0;
        end
      end
    end else if (flush_i) begin
      rr_r <= '0;
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_r[s] <= '0;
        wr_ptr_r[s] <= '0;
        cnt_r[s]    <= '0;
      end
    end else begin
      rr_r <= rr_nxt_s;
      if (|drop_s) begin
        overflow_r <= 1'b1;
      end
      for (int s = 0; s < NR_SRC; s++) begin
        if (push_s[s]) begin
          mem_r[s][wr_ptr_r[s]] <= in_entry_s[s];
          wr_ptr_r[s] <= (wr_ptr_r[s] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r[s] + PTR_W'(1);
        end
        if (pop_s[s]) begin
          rd_ptr_r[s] <= (rd_ptr_r[s] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r[s] + PTR_W'(1);
        end
        case ({push_s[s], pop_s[s]})
          2'b10:   cnt_r[s] <= cnt_r[s] + CNT_W'(1);
          2'b01:   cnt_r[s] <= cnt_r[s] - CNT_W'(1);
          default: cnt_r[s] <= cnt_r[s];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized bench for wb_arbiter against a queue-based reference model.
// Honours WB_ARB_BYPASS_EN in the model so it can be built with either configuration.
module tb_wb_arbiter;

  localparam int NR_SRC = 5;
  localparam int NR_WB_PORTS = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int TID = 3;
  localparam int XLEN = 32;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic                          flush_i;
  logic [NR_SRC-1:0]             src_valid_i;
  logic [NR_SRC*TID-1:0]         src_trans_id_i;
  logic [NR_SRC*XLEN-1:0]        src_result_i;
  logic [NR_SRC-1:0]             src_ex_valid_i;
  logic [NR_SRC*XLEN-1:0]        src_ex_cause_i;
  logic [NR_SRC-1:0]             src_afull_o;
  logic [NR_WB_PORTS-1:0]        wb_valid_o;
  logic [NR_WB_PORTS*TID-1:0]    wb_trans_id_o;
  logic [NR_WB_PORTS*XLEN-1:0]   wb_result_o;
  logic [NR_WB_PORTS-1:0]        wb_ex_valid_o;
  logic [NR_WB_PORTS*XLEN-1:0]   wb_ex_cause_o;
  logic                          overflow_o;

  wb_arbiter #(.NR_SRC(NR_SRC), .NR_WB_PORTS(NR_WB_PORTS), .FIFO_DEPTH(FIFO_DEPTH),
               .TRANS_ID_BITS(TID), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i), .src_result_i(src_result_i),
    .src_ex_valid_i(src_ex_valid_i), .src_ex_cause_i(src_ex_cause_i),
    .src_afull_o(src_afull_o), .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TID-1:0]  id;
    logic [XLEN-1:0] res;
    logic            exv;
    logic [XLEN-1:0] cause;
  } ent_t;

  ent_t q [NR_SRC][$];
  int   rr;
  bit   ovf;
  bit   model_ok;
  int   g_src[$];
  bit   g_byp[$];
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t input_ent(input int s);
    ent_t e;
    e.id    = src_trans_id_i[s*TID +: TID];
    e.res   = src_result_i[s*XLEN +: XLEN];
    e.exv   = src_ex_valid_i[s];
    e.cause = src_ex_cause_i[s*XLEN +: XLEN];
    return e;
  endfunction

  task automatic drive_idle();
    src_valid_i = '0; src_trans_id_i = '0; src_result_i = '0;
    src_ex_valid_i = '0; src_ex_cause_i = '0;
  endtask

  task automatic drive_rand(input int pct);
    for (int s = 0; s < NR_SRC; s++) begin
      src_valid_i[s]                = ($urandom_range(99) < pct);
      src_trans_id_i[s*TID +: TID]  = TID'($urandom);
      src_result_i[s*XLEN +: XLEN]  = $urandom;
      src_ex_valid_i[s]             = 1'($urandom);
      src_ex_cause_i[s*XLEN +: XLEN] = $urandom;
    end
  endtask

  task automatic drive_one(input int s, input logic [TID-1:0] id, input logic [XLEN-1:0] res,
                           input logic exv, input logic [XLEN-1:0] cause);
    src_valid_i[s]                 = 1'b1;
    src_trans_id_i[s*TID +: TID]   = id;
    src_result_i[s*XLEN +: XLEN]   = res;
    src_ex_valid_i[s]              = exv;
    src_ex_cause_i[s*XLEN +: XLEN] = cause;
  endtask

  // Derive this cycle's grants from the queues and compare the outputs.
  task automatic check_outputs();
    logic [NR_WB_PORTS-1:0] exp_v;
    logic [NR_SRC-1:0]      exp_af;
    ent_t e;
    int s;
    g_src.delete();
    g_byp.delete();
    for (int i = 0; i < NR_SRC; i++) begin
      s = (rr + i) % NR_SRC;
      if (g_src.size() < NR_WB_PORTS) begin
        if (q[s].size() > 0) begin
          g_src.push_back(s); g_byp.push_back(1'b0);
        end else if (BYP && src_valid_i[s] && !flush_i) begin
          g_src.push_back(s); g_byp.push_back(1'b1);
        end
      end
    end
    if (model_ok) begin
      exp_v = '0;
      foreach (g_src[k]) exp_v[k] = 1'b1;
      chk("wb_valid", 64'(wb_valid_o), 64'(exp_v));
      foreach (g_src[k]) begin
        e = g_byp[k] ? input_ent(g_src[k]) : q[g_src[k]][0];
        chk("wb_trans_id", 64'(wb_trans_id_o[k*TID +: TID]), 64'(e.id));
        chk("wb_result", 64'(wb_result_o[k*XLEN +: XLEN]), 64'(e.res));
        chk("wb_ex_valid", 64'(wb_ex_valid_o[k]), 64'(e.exv));
        chk("wb_ex_cause", 64'(wb_ex_cause_o[k*XLEN +: XLEN]), 64'(e.cause));
      end
      for (int j = 0; j < NR_SRC; j++) exp_af[j] = (q[j].size() >= FIFO_DEPTH - 1);
      chk("src_afull", 64'(src_afull_o), 64'(exp_af));
      chk("overflow", 64'(overflow_o), 64'(ovf));
    end
  endtask

  // Advance the reference model across one rising edge.
  task automatic update_model();
    bit byp [NR_SRC];
    if (!rst_ni) begin
      for (int s = 0; s < NR_SRC; s++) q[s].delete();
      rr = 0; ovf = 1'b0; model_ok = 1'b1;
    end else if (flush_i) begin
      for (int s = 0; s < NR_SRC; s++) q[s].delete();
      rr = 0;
    end else begin
      for (int s = 0; s < NR_SRC; s++) byp[s] = 1'b0;
      foreach (g_src[k]) begin
        if (g_byp[k]) byp[g_src[k]] = 1'b1;
        else void'(q[g_src[k]].pop_front());
      end
      for (int s = 0; s < NR_SRC; s++) begin
        if (src_valid_i[s] && !byp[s]) begin
          if (q[s].size() < FIFO_DEPTH) q[s].push_back(input_ent(s));
          else ovf = 1'b1;
        end
      end
      if (g_src.size() > 0) rr = (g_src[g_src.size()-1] + 1) % NR_SRC;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    update_model();
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; model_ok = 1'b0; rr = 0; ovf = 1'b0;
    rst_ni = 1'b0; flush_i = 1'b0; drive_idle();
    @(posedge clk_i); #1;
    tick();
    rst_ni = 1'b1;

    // Reset state: nothing valid, data zero, flags clear
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_result", wb_result_o, 64'd0);
    chk("rst_wb_trans_id", 64'(wb_trans_id_o), 64'd0);
    chk("rst_afull", 64'(src_afull_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    tick();

    // Single push on source 0
    drive_one(0, 3'd3, 32'h0000_DEAD, 1'b0, 32'h0);
`ifndef WB_ARB_BYPASS_EN
    chk("single_c0_valid", 64'(wb_valid_o), 64'd0);
`endif
    tick();
    drive_idle();
`ifndef WB_ARB_BYPASS_EN
    chk("single_c1_valid", 64'(wb_valid_o), 64'd1);
    chk("single_c1_id", 64'(wb_trans_id_o[TID-1:0]), 64'd3);
    chk("single_c1_res", 64'(wb_result_o[XLEN-1:0]), 64'h0000_DEAD);
`endif
    tick();
    chk("single_c2_valid", 64'(wb_valid_o), 64'd0);
    tick();

    // All sources push once; drains over three cycles
    drive_rand(100);
    tick();
    drive_idle();
    repeat (4) tick();

    // Exception on source 3
    drive_one(3, 3'd5, 32'h1234_5678, 1'b1, 32'h5);
    tick();
    drive_idle();
    repeat (2) tick();

    // Sources 0..2 busy, then drain
    for (int c = 0; c < 8; c++) begin
      drive_idle();
      for (int s = 0; s < 3; s++) drive_one(s, TID'(c + s), $urandom, 1'b0, 32'h0);
      tick();
    end
    drive_idle();
    repeat (6) tick();

    // Saturate everything to force drops, then flush with pushes, then reset
    repeat (6) begin drive_rand(100); tick(); end
    flush_i = 1'b1; drive_rand(100); tick();
    flush_i = 1'b0; drive_idle(); tick();
    chk("ovf_sticky_after_flush", 64'(overflow_o), 64'd1);
    chk("flush_empty_valid", 64'(wb_valid_o), 64'd0);
    tick();
    rst_ni = 1'b0; flush_i = 1'b1; tick();
    rst_ni = 1'b1; flush_i = 1'b0; tick();
    chk("ovf_cleared_by_reset", 64'(overflow_o), 64'd0);

    // Randomized traffic at several loads with occasional flush/reset
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 800; c++) begin
        drive_rand(ph == 0 ? 20 : (ph == 1 ? 50 : 85));
        flush_i = ($urandom_range(99) < 2);
        rst_ni  = !($urandom_range(999) < 5);
        tick();
      end
    end
    rst_ni = 1'b1; flush_i = 1'b0; drive_idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
